board_gen_ctrl: RTL and testbench

//  Sequencer that builds a fresh Minesweeper board in the board RAM when the game FSM enters NEW_GAME.
//  It runs three phases on the single RAM port: clear all cells, place mines at LFSR-chosen positions,

---
 rtl/board_gen_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_board_gen_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_gen_ctrl.sv
// Minesweeper board generator: clears the board RAM, places mines at LFSR-chosen cells
// away from the first click, then writes each cell's neighbour mine count.
module board_gen_ctrl #(
  parameter int unsigned MAX_SIZE  = 16,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W:0]   board_size,
  input  logic [ADDR_W-1:0]  mine_count,
  input  logic [COORD_W-1:0] safe_x,
  input  logic [COORD_W-1:0] safe_y,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic [4:0]         ram_wdata,
  input  logic [4:0]         ram_rdata
);

  localparam int unsigned NnW = 2 * COORD_W + 1;
  localparam logic [COORD_W:0] MinN = (COORD_W + 1)'(2);
  localparam logic [COORD_W:0] MaxN = (COORD_W + 1)'(MAX_SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StPlace,
    StPChk,
    StCount,
    StCWrite,
    StFinish
  } state_e;

  // Neighbour offset encoding: 0 = -1, 1 = 0, 2 = +1.
  localparam logic [1:0] OffM = 2'd0;
  localparam logic [1:0] OffZ = 2'd1;
  localparam logic [1:0] OffP = 2'd2;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q;
  logic [COORD_W:0]   n_q, n_d;
  logic [ADDR_W-1:0]  rem_q, rem_d;
  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [ADDR_W-1:0]  clr_q, clr_d;
  logic [3:0]         k_q, k_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               centre_q, centre_d;
  logic               pend_c_q, pend_c_d;
  logic               pend_n_q, pend_n_d;
  logic               rej_q, rej_d;

  logic [NnW-1:0]     nn;
  logic               req_bad;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic               cand_ok;
  logic [1:0]         dx, dy;
  logic [COORD_W-1:0] nx, ny;
  logic               last_x, last_y;
  logic               nbr_ok;
  logic [3:0]         cnt_sum;

  assign nn      = NnW'(board_size) * NnW'(board_size);
  assign req_bad = (board_size < MinN) || (board_size > MaxN) ||
                   ({1'b0, safe_x} >= board_size) || ({1'b0, safe_y} >= board_size) ||
                   (NnW'(mine_count) >= nn);

  assign cand_x  = lfsr_q[COORD_W-1:0];
  assign cand_y  = lfsr_q[2*COORD_W-1:COORD_W];
  assign cand_ok = ({1'b0, cand_x} < n_q) && ({1'b0, cand_y} < n_q) &&
                   !((cand_x == sx_q) && (cand_y == sy_q));

  assign last_x  = ({1'b0, cx_q} == (n_q - (COORD_W + 1)'(1)));
  assign last_y  = ({1'b0, cy_q} == (n_q - (COORD_W + 1)'(1)));

  always_comb begin
    dx = OffZ;
    dy = OffZ;
    case (k_q)
      4'd1:    begin dy = OffM; dx = OffM; end
      4'd2:    begin dy = OffM; dx = OffZ; end
      4'd3:    begin dy = OffM; dx = OffP; end
      4'd4:    begin dy = OffZ; dx = OffM; end
      4'd5:    begin dy = OffZ; dx = OffP; end
      4'd6:    begin dy = OffP; dx = OffM; end
      4'd7:    begin dy = OffP; dx = OffZ; end
      4'd8:    begin dy = OffP; dx = OffP; end
      default: begin dy = OffZ; dx = OffZ; end
    endcase
  end

  // Bounds are tested on the offset before the address is formed, so edges never wrap.
  assign nbr_ok = !((dx == OffM) && (cx_q == '0)) && !((dx == OffP) && last_x) &&
                  !((dy == OffM) && (cy_q == '0)) && !((dy == OffP) && last_y);
  assign nx = (dx == OffM) ? cx_q - COORD_W'(1) : (dx == OffP) ? cx_q + COORD_W'(1) : cx_q;
  assign ny = (dy == OffM) ? cy_q - COORD_W'(1) : (dy == OffP) ? cy_q + COORD_W'(1) : cy_q;

  assign cnt_sum = cnt_q + {3'b000, pend_n_q & ram_rdata[4]};

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    rem_d     = rem_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    clr_d     = clr_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    centre_d  = centre_q;
    pend_c_d  = 1'b0;
    pend_n_d  = 1'b0;
    rej_d     = rej_q;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (req_bad) begin
            rej_d   = 1'b1;
            state_d = StFinish;
          end else begin
            rej_d   = 1'b0;
            n_d     = board_size;
            rem_d   = mine_count;
            sx_d    = safe_x;
            sy_d    = safe_y;
            clr_d   = '0;
            state_d = StClear;
          end
        end
      end

      StClear: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_q;
        ram_wdata = 5'h00;
        clr_d     = clr_q + ADDR_W'(1);
        if (clr_q == '1) begin
          cx_d     = '0;
          cy_d     = '0;
          k_d      = '0;
          cnt_d    = '0;
          centre_d = 1'b0;
          state_d  = (rem_q == '0) ? StCount : StPlace;
        end
      end

      StPlace: begin
        busy = 1'b1;
        if (cand_ok) begin
          ram_addr = {cand_y, cand_x};
          cx_d     = cand_x;
          cy_d     = cand_y;
          state_d  = StPChk;
        end
      end

      StPChk: begin
        busy     = 1'b1;
        ram_addr = {cy_q, cx_q};
        if (ram_rdata[4]) begin
          state_d = StPlace;
        end else begin
          ram_we    = 1'b1;
          ram_wdata = 5'h10;
          rem_d     = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            cx_d     = '0;
            cy_d     = '0;
            k_d      = '0;
            cnt_d    = '0;
            centre_d = 1'b0;
            state_d  = StCount;
          end else begin
            state_d = StPlace;
          end
        end
      end

      StCount: begin
        busy = 1'b1;
        // Consume the read issued last cycle, then issue this step's read.
        if (pend_c_q) centre_d = ram_rdata[4];
        cnt_d = cnt_sum;
        if (k_q == 4'd0) begin
          ram_addr = {cy_q, cx_q};
          pend_c_d = 1'b1;
        end else if (nbr_ok) begin
          ram_addr = {ny, nx};
          pend_n_d = 1'b1;
        end
        k_d = k_q + 4'd1;
        if (k_q == 4'd8) state_d = StCWrite;
      end

      StCWrite: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {cy_q, cx_q};
        ram_wdata = {centre_q, cnt_sum};
        k_d       = '0;
        cnt_d     = '0;
        centre_d  = 1'b0;
        state_d   = StCount;
        if (last_x) begin
          cx_d = '0;
          if (last_y) state_d = StFinish;
          else        cy_d    = cy_q + COORD_W'(1);
        end else begin
          cx_d = cx_q + COORD_W'(1);
        end
      end

      StFinish: begin
        done    = 1'b1;
        err     = rej_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      lfsr_q   <= LFSR_SEED;
      n_q      <= '0;
      rem_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      clr_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      centre_q <= 1'b0;
      pend_c_q <= 1'b0;
      pend_n_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Free-running so placement depends on when start arrives.
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      n_q      <= n_d;
      rem_q    <= rem_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      clr_q    <= clr_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      centre_q <= centre_d;
      pend_c_q <= pend_c_d;
      pend_n_q <= pend_n_d;
      rej_q    <= rej_d;
    end
  end

endmodule

// File: tb/tb_board_gen_ctrl.sv
// Directed bench for board_gen_ctrl with a synchronous-read RAM model and a golden
// neighbour-count recompute over the model contents.
module tb_board_gen_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] board_size;
  logic [7:0] mine_count;
  logic [3:0] safe_x;
  logic [3:0] safe_y;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [4:0] ram_wdata;
  logic [4:0] ram_rdata;

  board_gen_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .board_size (board_size),
    .mine_count (mine_count),
    .safe_x     (safe_x),
    .safe_y     (safe_y),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] mem [0:255];
  logic       fill;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 5'h1f;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  int done_cnt = 0;
  int we_cnt   = 0;
  int busy_cnt = 0;

  always @(posedge clk) begin
    if (done)   done_cnt <= done_cnt + 1;
    if (ram_we) we_cnt   <= we_cnt + 1;
    if (busy)   busy_cnt <= busy_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  int mines_in, junk_out, bad_cnt, nonzero;
  logic safe_mined;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [4:0] n, input logic [7:0] m,
                             input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    board_size = n;
    mine_count = m;
    safe_x     = x;
    safe_y     = y;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic seen, output logic e);
    seen = 1'b0;
    e    = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        seen = 1'b1;
        e    = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic analyze(input int n, input int sx, input int sy);
    logic [4:0] w;
    int g;
    mines_in = 0;
    junk_out = 0;
    bad_cnt  = 0;
    nonzero  = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        w = mem[y * 16 + x];
        if (w != 5'h00) nonzero++;
        if (x < n && y < n) begin
          if (w[4]) mines_in++;
          g = 0;
          for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
              if (!(dx == 0 && dy == 0) && (x + dx >= 0) && (x + dx < n) &&
                  (y + dy >= 0) && (y + dy < n)) begin
                if (mem[(y + dy) * 16 + (x + dx)][4]) g++;
              end
            end
          end
          if (int'(w[3:0]) != g) bad_cnt++;
        end else if (w != 5'h00) begin
          junk_out++;
        end
      end
    end
    safe_mined = mem[sy * 16 + sx][4];
  endtask

  initial begin
    logic seen, e;
    int   d0, w0, b0;

    rst        = 1'b1;
    start      = 1'b0;
    board_size = '0;
    mine_count = '0;
    safe_x     = '0;
    safe_y     = '0;
    fill       = 1'b1;
    repeat (3) @(negedge clk);
    fill = 1'b0;
    rst  = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst we", ram_we, 0);
    check("rst addr", ram_addr, 0);
    check("rst wdata", ram_wdata, 0);

    // 1: N=8, M=10, safe (3,3)
    pulse_start(5'd8, 8'd10, 4'd3, 4'd3);
    check("t1 busy", busy, 1);
    wait_done(20000, seen, e);
    check("t1 done", seen, 1);
    check("t1 err", e, 0);
    @(negedge clk);
    analyze(8, 3, 3);
    check("t1 mines", mines_in, 10);
    check("t1 outside", junk_out, 0);
    check("t1 counts", bad_cnt, 0);
    check("t1 safe", safe_mined, 0);

    // 2: N=8, M=63, safe (0,0)
    pulse_start(5'd8, 8'd63, 4'd0, 4'd0);
    wait_done(20000, seen, e);
    check("t2 done", seen, 1);
    check("t2 err", e, 0);
    @(negedge clk);
    analyze(8, 0, 0);
    check("t2 mines", mines_in, 63);
    check("t2 counts", bad_cnt, 0);
    check("t2 cell00", mem[8'h00], 5'h03);
    check("t2 cell77", mem[8'h77], 5'h13);

    // 3: N=8, M=64 is rejected
    w0 = we_cnt;
    b0 = busy_cnt;
    pulse_start(5'd8, 8'd64, 4'd0, 4'd0);
    check("t3 done", done, 1);
    check("t3 err", err, 1);
    check("t3 busy", busy, 0);
    @(negedge clk);
    check("t3 done low", done, 0);
    check("t3 we cnt", we_cnt - w0, 0);
    check("t3 busy cnt", busy_cnt - b0, 0);

    // 4: N=16, M=0
    d0 = done_cnt;
    pulse_start(5'd16, 8'd0, 4'd5, 4'd9);
    wait_done(20000, seen, e);
    check("t4 done", seen, 1);
    check("t4 err", e, 0);
    repeat (3) @(negedge clk);
    analyze(16, 5, 9);
    check("t4 nonzero", nonzero, 0);
    check("t4 done cnt", done_cnt - d0, 1);

    // 5: second start while busy is ignored
    d0 = done_cnt;
    pulse_start(5'd4, 8'd3, 4'd1, 4'd1);
    repeat (5) @(negedge clk);
    pulse_start(5'd8, 8'd20, 4'd0, 4'd0);
    wait_done(20000, seen, e);
    check("t5 done", seen, 1);
    check("t5 err", e, 0);
    repeat (3) @(negedge clk);
    analyze(4, 1, 1);
    check("t5 mines", mines_in, 3);
    check("t5 outside", junk_out, 0);
    check("t5 counts", bad_cnt, 0);
    check("t5 safe", safe_mined, 0);
    check("t5 done cnt", done_cnt - d0, 1);

    // 6: reset during placement, then a fresh N=5 board
    pulse_start(5'd8, 8'd10, 4'd2, 4'd2);
    repeat (258) @(negedge clk);
    check("t6 busy pre", busy, 1);
    rst = 1'b1;
    #1;
    check("t6 busy", busy, 0);
    check("t6 we", ram_we, 0);
    check("t6 done", done, 0);
    @(negedge clk);
    check("t6 busy held", busy, 0);
    rst = 1'b0;
    pulse_start(5'd5, 8'd5, 4'd4, 4'd4);
    wait_done(20000, seen, e);
    check("t6b done", seen, 1);
    check("t6b err", e, 0);
    @(negedge clk);
    analyze(5, 4, 4);
    check("t6b mines", mines_in, 5);
    check("t6b outside", junk_out, 0);
    check("t6b counts", bad_cnt, 0);
    check("t6b safe", safe_mined, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
